bldc_hall_speed: RTL

Consumes the debounced hall code and its change pulse from the hall-capture stage. Produces the commutation step index, rotation direction, the period between hall edges in clk cycles, a stall flag and a sequence-error pulse. Sits between hall capture and the BLDC register/PWM commutation logic; all outputs are registered.

---
 rtl/bldc_hall_speed.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/bldc_hall_speed.sv
// Hall-sensor speed/direction tracker: step index, direction, edge period, stall and error.
// Define BLDC_HALL_SPEED_AVG_EN to report a 4-period running mean instead of the raw period.
module bldc_hall_speed #(
  parameter int              CNT_W       = 24,
  parameter logic [CNT_W-1:0] STALL_LIMIT = 24'd12000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       hall_data_i,
  input  logic             hall_change_i,
  output logic [2:0]       step_o,
  output logic             dir_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_vld_o,
  output logic             stall_o,
  output logic             hall_err_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    RUN   = 2'd2,
    STALL = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [2:0]       step_q, step_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pvld_q, pvld_d;
  logic             stall_q, stall_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  function automatic logic [2:0] code2step(input logic [2:0] c);
    logic [2:0] s;
    s = 3'd0;
    case (c)
      3'd5:    s = 3'd0;
      3'd4:    s = 3'd1;
      3'd6:    s = 3'd2;
      3'd2:    s = 3'd3;
      3'd3:    s = 3'd4;
      3'd1:    s = 3'd5;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] step_inc(input logic [2:0] s);
    return (s == 3'd5) ? 3'd0 : s + 3'd1;
  endfunction

  function automatic logic [2:0] step_dec(input logic [2:0] s);
    return (s == 3'd0) ? 3'd5 : s - 3'd1;
  endfunction

  logic       legal;
  logic [2:0] nstep;
  logic       is_fwd;
  logic       is_rev;

  assign legal  = (hall_data_i != 3'd0) && (hall_data_i != 3'd7);
  assign nstep  = code2step(hall_data_i);
  assign is_fwd = (nstep == step_inc(step_q));
  assign is_rev = (nstep == step_dec(step_q));

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    dir_d    = dir_q;
    stall_d  = stall_q;
    pvld_d   = 1'b0;
    err_d    = 1'b0;
    accept   = 1'b0;
    cnt_d    = (&cnt_q) ? cnt_q : cnt_q + ONE;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      stall_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d   = '0;
          stall_d = 1'b0;
          state_d = SYNC;
        end
        SYNC: begin
          if (hall_change_i) begin
            if (legal) begin
              step_d  = nstep;
              cnt_d   = ONE;
              state_d = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        RUN: begin
          if (hall_change_i) begin
            if (!legal) begin
              err_d   = 1'b1;
              state_d = SYNC;
            end else begin
              step_d = nstep;
              cnt_d  = ONE;
              if ((dir_q && is_fwd) || (!dir_q && is_rev)) begin
                accept = 1'b1;
                pvld_d = 1'b1;
              end else if (is_fwd || is_rev) begin
                // reversal: the straddling interval mixes two directions
                dir_d = ~dir_q;
              end else begin
                err_d = 1'b1;
              end
            end
          end else if (cnt_q == STALL_LIMIT) begin
            state_d = STALL;
            stall_d = 1'b1;
          end
        end
        STALL: begin
          if (hall_change_i) begin
            if (legal) begin
              stall_d = 1'b0;
              step_d  = nstep;
              cnt_d   = ONE;
              state_d = RUN;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef BLDC_HALL_SPEED_AVG_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];
  logic [CNT_W+1:0] sum_q, sum_d;
  logic             prime_q, prime_d;

  always_comb begin
    hist_d   = hist_q;
    sum_d    = sum_q;
    prime_d  = prime_q;
    period_d = period_q;
    if (state_q != RUN) prime_d = 1'b1;
    if (!en_i || state_q == IDLE) begin
      period_d = '0;
    end else if (accept) begin
      prime_d = 1'b0;
      if (prime_q) begin
        for (int i = 0; i < 4; i++) hist_d[i] = cnt_q;
        sum_d = {cnt_q, 2'b00};
      end else begin
        sum_d     = sum_q - {2'b00, hist_q[3]} + {2'b00, cnt_q};
        hist_d[3] = hist_q[2];
        hist_d[2] = hist_q[1];
        hist_d[1] = hist_q[0];
        hist_d[0] = cnt_q;
      end
      period_d = sum_d[CNT_W+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist_q[i] <= '0;
      sum_q   <= '0;
      prime_q <= 1'b1;
    end else begin
      hist_q  <= hist_d;
      sum_q   <= sum_d;
      prime_q <= prime_d;
    end
  end
`else
  always_comb begin
    period_d = period_q;
    if (!en_i || state_q == IDLE) period_d = '0;
    else if (accept) period_d = cnt_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      step_q   <= 3'd0;
      dir_q    <= 1'b1;
      period_q <= '0;
      pvld_q   <= 1'b0;
      stall_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      pvld_q   <= pvld_d;
      stall_q  <= stall_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign step_o       = step_q;
  assign dir_o        = dir_q;
  assign period_o     = period_q;
  assign period_vld_o = pvld_q;
  assign stall_o      = stall_q;
  assign hall_err_o   = err_q;
  assign state_o      = state_q;

endmodule
